episode_scheduler: RTL and testbench
====================================

Name: episode_scheduler

Overview:
- Sequences Q-learning training episodes over the 5x5 maze, states 1..25, start 1, goal 25.
- Each step it chooses an epsilon-greedy action, applies it to the state selector, and hands the resulting transition to the Q-learning agent.
- It then waits for the agent's update to complete and decides whether to continue the episode, start a new one, or finish.
- Sits between the top-level control wrapper and the agent/state-selector/reward datapath.

Parameters:
- MAX_STEPS, 64: step limit per episode; reaching it ends the episode (timeout).
- N_EPISODES, 256: number of episodes per training run.
- START_STATE, 1: state loaded at every episode start.
- LFSR_SEED, 16'hACE1: LFSR reset value; must be non-zero.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- en  in  1  global enable; when 0, all registers hold, including the LFSR
- start  in  1  pulse: begin a training run (accepted in IDLE or DONE only)
- epsilon  in  8  exploration threshold; 0 = always greedy, 255 = explore 255/256
- greedy_action  in  4  agent argmax action, one-hot {right,left,down,up}
- next_state  in  6  state selector result for current_state + next_action
- hit_goal  in  1  next_state == 25 (from maze classification)
- hit_trap  in  1  next_state is a trap cell
- upd_ack  in  1  agent finished the Q-update for the presented transition
- current_state  out  6  registered current maze state
- next_action  out  4  registered one-hot action
- upd_req  out  1  request the agent to update Q(current_state, next_action)
- busy  out  1  high in every state except IDLE and DONE
- done  out  1  high in DONE
- episode_cnt  out  16  completed episodes
- step_cnt  out  7  steps taken in the current episode
- goal_cnt  out  16  episodes that ended at the goal

Behaviour:
- Reset values: current_state = START_STATE, next_action = 0, upd_req = 0, busy = 0, done = 0, all counters = 0, LFSR = LFSR_SEED, FSM = IDLE.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. Advances every en cycle regardless of FSM state.
- IDLE: on start, clear episode_cnt and goal_cnt, set current_state = START_STATE and step_cnt = 0, then go to SELECT.
- SELECT (1 cycle):
  - If lfsr[7:0] < epsilon, next_action = onehot(lfsr[9:8]); otherwise next_action = greedy_action.
  - If greedy_action is not one-hot, use onehot(lfsr[9:8]) instead.
  - Go to UPDATE.
- UPDATE:
  - Assert upd_req, holding current_state and next_action stable.
  - Stay until upd_ack is sampled high; on ack, drop upd_req in the next cycle and go to CHECK.
  - Each request completes exactly one ack. An upd_ack outside UPDATE is ignored.
- CHECK (1 cycle):
  - Increment step_cnt.
  - If hit_goal: increment goal_cnt and go to EP_END.
  - Else if hit_trap, or step_cnt+1 == MAX_STEPS: go to EP_END.
  - Otherwise: current_state = next_state, go to SELECT.
  - hit_goal has priority over hit_trap.
- EP_END (1 cycle):
  - Increment episode_cnt, set current_state = START_STATE, step_cnt = 0.
  - If episode_cnt+1 == N_EPISODES, go to DONE; else go to SELECT.
- DONE: done = 1; a new start restarts the run exactly as from IDLE.
- start while busy: ignored.
- Minimum step latency: SELECT + UPDATE (1 cycle if ack is immediate) + CHECK = 3 cycles.
- Counters: episode_cnt and goal_cnt saturate at 16'hFFFF. step_cnt never exceeds MAX_STEPS.
- rst_n asserted mid-run: immediate return to reset values; any pending upd_req is dropped.
- en low mid-handshake: the FSM freezes with upd_req held; an ack arriving while en = 0 is not sampled.

Optional Feature:
- Macro EPS_DECAY_EN.
- Defined: an internal 8-bit eps_r is loaded from epsilon on start and decremented by 1 at each EP_END, saturating at 0. SELECT compares against eps_r.
- Undefined: SELECT compares directly against the epsilon port; no eps_r register exists.

Decomposition:
- rl_pkg holds:
  - action encodings ACT_UP = 4'b0001, ACT_DOWN = 4'b0010, ACT_LEFT = 4'b0100, ACT_RIGHT = 4'b1000
  - START_STATE / GOAL_STATE = 25 constants
  - the 6-bit state width
  - the FSM state enum {IDLE, SELECT, UPDATE, CHECK, EP_END, DONE}
- One sub-module, lfsr16: enable, seed, 16-bit output. It is reusable by other random-exploration logic.

Test Plan:
- Greedy walk: epsilon = 0, greedy_action = ACT_RIGHT, ack tied high, next_state = current+1 → next_action always 4'b1000; reaching state 25 increments goal_cnt to 1 and episode_cnt to 1, and current_state returns to 1.
- Trap termination: next_state = 3 with hit_trap = 1 at step 2 → episode ends with step_cnt = 2 seen in CHECK; goal_cnt stays 0.
- Timeout: hit_goal = hit_trap = 0 forever, MAX_STEPS = 64 → EP_END after exactly 64 acks.
- Handshake stall: upd_ack delayed 5 cycles → upd_req high for 5 cycles with current_state/next_action constant; a spurious ack in SELECT is ignored.
- Full run: N_EPISODES = 4, immediate goal each step → done = 1 after episode 4; start then restarts with counters at 0.
- Async reset: rst_n low during UPDATE → upd_req = 0 and busy = 0 immediately; LFSR = 16'hACE1 after release. With EPS_DECAY_EN, epsilon = 3 gives eps_r 3→2→1→0→0 across episodes.

Source files
------------

// File: rtl/rl_pkg.sv
// Shared definitions for the Q-learning maze training blocks.
//   - Action one-hot encodings ({right,left,down,up}).
//   - Maze state width and the default start / goal cells.
//   - Episode scheduler FSM state type.
//   - Helpers for building and validating one-hot actions.
package rl_pkg;

   localparam int unsigned STATE_W = 6;

   localparam logic [STATE_W-1:0] START_STATE_DEF = 6'd1;
   localparam logic [STATE_W-1:0] GOAL_STATE      = 6'd25;

   localparam logic [3:0] ACT_UP    = 4'b0001;
   localparam logic [3:0] ACT_DOWN  = 4'b0010;
   localparam logic [3:0] ACT_LEFT  = 4'b0100;
   localparam logic [3:0] ACT_RIGHT = 4'b1000;

   typedef enum logic [2:0] {
      IDLE,
      SELECT,
      UPDATE,
      CHECK,
      EP_END,
      DONE
   } sched_state_e;

   // Map a 2-bit random index onto one of the four one-hot actions.
   function automatic logic [3:0] onehot_act(input logic [1:0] idx);
      logic [3:0] act;
      unique case (idx)
         2'd0:    act = ACT_UP;
         2'd1:    act = ACT_DOWN;
         2'd2:    act = ACT_LEFT;
         default: act = ACT_RIGHT;
      endcase
      return act;
   endfunction

   function automatic logic is_onehot4(input logic [3:0] v);
      return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
   endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Fibonacci LFSR, taps 16,14,13,11, shifting left.
// Reusable source of pseudo-random bits for exploration logic.
// Ports:
//   clk_i   system clock
//   rst_ni  asynchronous active-low reset, loads seed_i
//   en_i    advance one step per cycle when high, hold otherwise
//   seed_i  reset value, must be non-zero (an all-zero LFSR locks up)
//   lfsr_o  current register value
module lfsr16 (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        en_i,
   input  logic [15:0] seed_i,
   output logic [15:0] lfsr_o
);

   logic [15:0] lfsr_q, lfsr_d;
   logic        fb;

   always_comb begin
      fb     = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
      lfsr_d = en_i ? {lfsr_q[14:0], fb} : lfsr_q;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         lfsr_q <= seed_i;
      end else begin
         lfsr_q <= lfsr_d;
      end
   end

   assign lfsr_o = lfsr_q;

endmodule

// File: rtl/episode_scheduler.sv
// Episode scheduler for Q-learning on the 5x5 maze (states 1..25).
// Picks an epsilon-greedy action, hands the transition to the agent via a
// req/ack handshake, then continues, ends the episode, or finishes the run.
// Optional build macro EPS_DECAY_EN: epsilon is latched at start and
// decremented (saturating at 0) at every episode end.
// Ports:
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   en_i                   global enable; all state (incl. LFSR) holds when low
//   start_i                begin a run (accepted only when idle or done)
//   epsilon_i              exploration threshold
//   greedy_action_i        agent argmax action, one-hot
//   next_state_i           selector result for current state + action
//   hit_goal_i, hit_trap_i classification of next_state_i
//   upd_ack_i              agent finished the requested Q-update
//   current_state_o        registered maze state
//   next_action_o          registered one-hot action
//   upd_req_o              Q-update request
//   busy_o, done_o         run status
//   episode_cnt_o, step_cnt_o, goal_cnt_o  progress counters
module episode_scheduler
   import rl_pkg::*;
#(
   parameter int unsigned          MAX_STEPS   = 64,
   parameter int unsigned          N_EPISODES  = 256,
   parameter logic [STATE_W-1:0]   START_STATE = START_STATE_DEF,
   parameter logic [15:0]          LFSR_SEED   = 16'hACE1
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic               en_i,
   input  logic               start_i,
   input  logic [7:0]         epsilon_i,
   input  logic [3:0]         greedy_action_i,
   input  logic [STATE_W-1:0] next_state_i,
   input  logic               hit_goal_i,
   input  logic               hit_trap_i,
   input  logic               upd_ack_i,
   output logic [STATE_W-1:0] current_state_o,
   output logic [3:0]         next_action_o,
   output logic               upd_req_o,
   output logic               busy_o,
   output logic               done_o,
   output logic [15:0]        episode_cnt_o,
   output logic [6:0]         step_cnt_o,
   output logic [15:0]        goal_cnt_o
);

   sched_state_e        state_q;
   logic [STATE_W-1:0]  cur_state_q;
   logic [3:0]          action_q, action_d;
   logic                upd_req_q, busy_q, done_q;
   logic [15:0]         ep_cnt_q, ep_cnt_d;
   logic [15:0]         goal_cnt_q, goal_cnt_d;
   logic [6:0]          step_cnt_q, step_cnt_d;
   logic                step_last, ep_last, explore;
   logic [15:0]         lfsr;
   logic [7:0]          eps_cmp;
   logic                unused_lfsr;

   lfsr16 u_lfsr (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .en_i   (en_i),
      .seed_i (LFSR_SEED),
      .lfsr_o (lfsr)
   );

   assign unused_lfsr = ^lfsr[15:10];

`ifdef EPS_DECAY_EN
   logic [7:0] eps_q;
   assign eps_cmp = eps_q;
`else
   assign eps_cmp = epsilon_i;
`endif

   always_comb begin
      // A malformed greedy action falls back to a random move.
      explore    = (lfsr[7:0] < eps_cmp) || !is_onehot4(greedy_action_i);
      action_d   = explore ? onehot_act(lfsr[9:8]) : greedy_action_i;
      step_cnt_d = step_cnt_q + 7'd1;
      step_last  = (32'(step_cnt_d) == MAX_STEPS);
      ep_cnt_d   = (ep_cnt_q == 16'hFFFF) ? ep_cnt_q : ep_cnt_q + 16'd1;
      goal_cnt_d = (goal_cnt_q == 16'hFFFF) ? goal_cnt_q : goal_cnt_q + 16'd1;
      ep_last    = ((32'(ep_cnt_q) + 32'd1) == N_EPISODES);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= IDLE;
         cur_state_q <= START_STATE;
         action_q    <= 4'd0;
         upd_req_q   <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         ep_cnt_q    <= 16'd0;
         goal_cnt_q  <= 16'd0;
         step_cnt_q  <= 7'd0;
`ifdef EPS_DECAY_EN
         eps_q       <= 8'd0;
`endif
      end else if (en_i) begin
         unique case (state_q)
            IDLE, DONE: begin
               if (start_i) begin
                  ep_cnt_q    <= 16'd0;
                  goal_cnt_q  <= 16'd0;
                  cur_state_q <= START_STATE;
                  step_cnt_q  <= 7'd0;
                  busy_q      <= 1'b1;
                  done_q      <= 1'b0;
`ifdef EPS_DECAY_EN
                  eps_q       <= epsilon_i;
`endif
                  state_q     <= SELECT;
               end
            end
            SELECT: begin
               action_q  <= action_d;
               upd_req_q <= 1'b1;
               state_q   <= UPDATE;
            end
            UPDATE: begin
               if (upd_ack_i) begin
                  upd_req_q <= 1'b0;
                  state_q   <= CHECK;
               end
            end
            CHECK: begin
               step_cnt_q <= step_cnt_d;
               if (hit_goal_i) begin
                  goal_cnt_q <= goal_cnt_d;
                  state_q    <= EP_END;
               end else if (hit_trap_i || step_last) begin
                  state_q    <= EP_END;
               end else begin
                  cur_state_q <= next_state_i;
                  state_q     <= SELECT;
               end
            end
            EP_END: begin
               ep_cnt_q    <= ep_cnt_d;
               cur_state_q <= START_STATE;
               step_cnt_q  <= 7'd0;
`ifdef EPS_DECAY_EN
               eps_q       <= (eps_q == 8'd0) ? 8'd0 : eps_q - 8'd1;
`endif
               if (ep_last) begin
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= DONE;
               end else begin
                  state_q <= SELECT;
               end
            end
            default: begin
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign current_state_o = cur_state_q;
   assign next_action_o   = action_q;
   assign upd_req_o       = upd_req_q;
   assign busy_o          = busy_q;
   assign done_o          = done_q;
   assign episode_cnt_o   = ep_cnt_q;
   assign step_cnt_o      = step_cnt_q;
   assign goal_cnt_o      = goal_cnt_q;

endmodule

// File: tb/tb_episode_scheduler.sv
// Self-checking bench for episode_scheduler (run length reduced to 4 episodes).
// A transaction-level model tracks the training run per accepted update
// (step, episode and goal bookkeeping, LFSR stream, action choice) and a
// compare process checks every request and every run completion against it.
module tb_episode_scheduler;

   localparam int unsigned MaxSteps = 64;
   localparam int unsigned NEp      = 4;
   localparam logic [15:0] Seed     = 16'hACE1;

   logic        clk, rst_n, en, start;
   logic [7:0]  epsilon;
   logic [3:0]  greedy;
   logic [5:0]  ns;
   logic        goal, trap, upd_ack;
   logic [5:0]  current_state;
   logic [3:0]  next_action;
   logic        upd_req, busy, done;
   logic [15:0] episode_cnt, goal_cnt;
   logic [6:0]  step_cnt;

   int          mode;
   logic        ack_tie, ack_man;
   int          n_checks = 0;
   int          n_fail   = 0;

   episode_scheduler #(
      .MAX_STEPS  (MaxSteps),
      .N_EPISODES (NEp),
      .START_STATE(6'd1),
      .LFSR_SEED  (Seed)
   ) dut (
      .clk_i          (clk),
      .rst_ni         (rst_n),
      .en_i           (en),
      .start_i        (start),
      .epsilon_i      (epsilon),
      .greedy_action_i(greedy),
      .next_state_i   (ns),
      .hit_goal_i     (goal),
      .hit_trap_i     (trap),
      .upd_ack_i      (upd_ack),
      .current_state_o(current_state),
      .next_action_o  (next_action),
      .upd_req_o      (upd_req),
      .busy_o         (busy),
      .done_o         (done),
      .episode_cnt_o  (episode_cnt),
      .step_cnt_o     (step_cnt),
      .goal_cnt_o     (goal_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Maze stand-in: 0 walk right, 1 trap at cell 3, 2 stay put, 3 goal at once.
   always_comb begin
      ns   = current_state + 6'd1;
      trap = 1'b0;
      case (mode)
         1:       trap = (ns == 6'd3);
         2:       ns = current_state;
         3:       ns = 6'd25;
         default: ;
      endcase
      goal = (ns == 6'd25);
   end

   assign upd_ack = ack_tie ? 1'b1 : ack_man;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [15:0] lfsr_next(input logic [15:0] l);
      logic b;
      b = l[15] ^ l[13] ^ l[12] ^ l[10];
      return {l[14:0], b};
   endfunction

   function automatic logic [3:0] pick(input logic [15:0] l, input logic [7:0] e,
                                       input logic [3:0] g);
      logic valid;
      valid = (g == 4'd1) || (g == 4'd2) || (g == 4'd4) || (g == 4'd8);
      if ((l[7:0] < e) || !valid) return 4'(1 << l[9:8]);
      return g;
   endfunction

   // ---------------- model + compare process ----------------
   logic [15:0] m_lfsr = Seed, lfsr_prev;
   logic [7:0]  eps_e, m_eps = 8'd0;
   logic [3:0]  greedy_e, exp_act = 4'd0;
   logic [5:0]  m_state = 6'd1;
   int          m_steps = 0, m_ep = 0, m_goal = 0, n_acks = 0, n_req = 0;
   logic        running = 1'b0, m_done = 1'b0;
   logic        req_last = 1'b0, done_last = 1'b0;

   always @(posedge clk) begin
      lfsr_prev = m_lfsr;
      eps_e     = epsilon;
      greedy_e  = greedy;
      if (!rst_n) begin
         m_lfsr  = Seed;
         running = 1'b0;
         m_done  = 1'b0;
         m_state = 6'd1;
         m_steps = 0;
         m_ep    = 0;
         m_goal  = 0;
      end else if (en) begin
         m_lfsr = lfsr_next(m_lfsr);
         if (req_last && upd_ack) begin
            n_acks++;
            m_steps++;
            if (goal || trap || m_steps == MaxSteps) begin
               if (goal && m_goal < 16'hFFFF) m_goal++;
               if (m_ep < 16'hFFFF) m_ep++;
               m_state = 6'd1;
               m_steps = 0;
               if (m_eps != 8'd0) m_eps = m_eps - 8'd1;
               if (m_ep == NEp) begin
                  running = 1'b0;
                  m_done  = 1'b1;
               end
            end else begin
               m_state = ns;
            end
         end
         if (start && !running) begin
            running = 1'b1;
            m_done  = 1'b0;
            m_state = 6'd1;
            m_steps = 0;
            m_ep    = 0;
            m_goal  = 0;
            m_eps   = epsilon;
         end
      end
      #1;
      if (upd_req && !req_last) begin
         n_req++;
`ifdef EPS_DECAY_EN
         exp_act = pick(lfsr_prev, m_eps, greedy_e);
`else
         exp_act = pick(lfsr_prev, eps_e, greedy_e);
`endif
         chk("req_busy", 32'(busy), 32'd1);
         chk("req_step_cnt", 32'(step_cnt), 32'(m_steps));
         chk("req_episode_cnt", 32'(episode_cnt), 32'(m_ep));
         chk("req_goal_cnt", 32'(goal_cnt), 32'(m_goal));
      end
      if (upd_req) begin
         chk("req_action", 32'(next_action), 32'(exp_act));
         chk("req_state", 32'(current_state), 32'(m_state));
      end
      if (done && !done_last) begin
         chk("done_model", 32'(m_done), 32'd1);
         chk("done_episode_cnt", 32'(episode_cnt), 32'(m_ep));
         chk("done_goal_cnt", 32'(goal_cnt), 32'(m_goal));
      end
      req_last  = upd_req;
      done_last = done;
   end

   // ---------------- directed sequence ----------------
   task automatic wait_ep(input int target, output int prev_step);
      bit ok;
      ok = 0;
      prev_step = -1;
      for (int i = 0; i < 1000; i++) begin
         @(posedge clk); #2;
         if (32'(episode_cnt) == target) begin
            ok = 1;
            break;
         end
         prev_step = int'(step_cnt);
      end
      chk("episode_reached", 32'(ok), 32'd1);
   endtask

   task automatic wait_sig_req();
      bit ok;
      ok = 0;
      for (int i = 0; i < 200; i++) begin
         @(posedge clk); #2;
         if (upd_req) begin
            ok = 1;
            break;
         end
      end
      chk("req_seen", 32'(ok), 32'd1);
   endtask

   task automatic wait_reqs(input int n);
      int target;
      bit ok;
      target = n_req + n;
      ok = 0;
      for (int i = 0; i < 500; i++) begin
         @(posedge clk); #2;
         if (n_req >= target) begin
            ok = 1;
            break;
         end
      end
      chk("reqs_reached", 32'(ok), 32'd1);
   endtask

   initial begin
      int prev, a0, cnt;
      bit ok;
      rst_n = 1'b0; en = 1'b1; start = 1'b0; epsilon = 8'd0;
      greedy = 4'b1000; mode = 0; ack_tie = 1'b0; ack_man = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_current_state", 32'(current_state), 32'd1);
      chk("rst_next_action", 32'(next_action), 32'd0);
      chk("rst_upd_req", 32'(upd_req), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_counters", 32'(episode_cnt) | 32'(goal_cnt) | 32'(step_cnt), 32'd0);
      rst_n = 1'b1;

      // Greedy walk right to the goal.
      @(negedge clk); ack_tie = 1'b1; start = 1'b1;
      @(negedge clk); start = 1'b0;
      wait_ep(1, prev);
      chk("walk_steps", 32'(prev), 32'd24);
      chk("walk_goal_cnt", 32'(goal_cnt), 32'd1);
      chk("walk_state_back", 32'(current_state), 32'd1);

      // Trap on the second step.
      mode = 1; a0 = n_acks;
      wait_ep(2, prev);
      chk("trap_steps", 32'(prev), 32'd2);
      chk("trap_acks", 32'(n_acks - a0), 32'd2);
      chk("trap_goal_cnt", 32'(goal_cnt), 32'd1);

      // Timeout.
      mode = 2; a0 = n_acks;
      wait_ep(3, prev);
      chk("timeout_steps", 32'(prev), 32'd64);
      chk("timeout_acks", 32'(n_acks - a0), 32'd64);

      // Last episode reaches the goal immediately; run completes.
      mode = 3; ok = 0;
      for (int i = 0; i < 100; i++) begin
         @(posedge clk); #2;
         if (done) begin
            ok = 1;
            break;
         end
      end
      chk("done_seen", 32'(ok), 32'd1);
      chk("done_episode_cnt_lit", 32'(episode_cnt), 32'd4);
      chk("done_goal_cnt_lit", 32'(goal_cnt), 32'd2);
      chk("done_busy", 32'(busy), 32'd0);

      // Restart from DONE with randomised actions; spurious ack in SELECT.
      ack_tie = 1'b0; epsilon = 8'hC0;
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0; ack_man = 1'b1;
      @(posedge clk); #2;
      chk("restart_req", 32'(upd_req), 32'd1);
      chk("restart_counters", 32'(episode_cnt) | 32'(goal_cnt), 32'd0);
      chk("restart_done_low", 32'(done), 32'd0);
      @(negedge clk); ack_man = 1'b0;
      cnt = 1;
      repeat (4) begin
         @(posedge clk); #2;
         if (upd_req) cnt++;
      end
      @(negedge clk); ack_man = 1'b1;
      @(posedge clk); #2;
      chk("stall_req_dropped", 32'(upd_req), 32'd0);
      chk("stall_req_cycles", 32'(cnt), 32'd5);
      @(negedge clk); ack_man = 1'b0;

      // Ack while disabled is not sampled.
      wait_sig_req();
      @(negedge clk); en = 1'b0; ack_man = 1'b1;
      repeat (2) @(negedge clk);
      ack_man = 1'b0; en = 1'b1;
      @(posedge clk); #2;
      chk("en_low_req_held", 32'(upd_req), 32'd1);
      chk("en_low_episode_cnt", 32'(episode_cnt), 32'd1);
      @(negedge clk); ack_man = 1'b1;
      @(posedge clk); #2;
      chk("en_high_ack", 32'(upd_req), 32'd0);
      @(negedge clk); ack_man = 1'b0;

      // Asynchronous reset during UPDATE.
      wait_sig_req();
      @(negedge clk); #2 rst_n = 1'b0;
      #1;
      chk("arst_upd_req", 32'(upd_req), 32'd0);
      chk("arst_busy", 32'(busy), 32'd0);
      chk("arst_state", 32'(current_state), 32'd1);
      chk("arst_counters", 32'(episode_cnt) | 32'(step_cnt), 32'd0);
      @(negedge clk); @(negedge clk); rst_n = 1'b1;

      // Fresh run: LFSR restarts from the seed; explore, bad greedy, mixed.
      mode = 0; ack_tie = 1'b1; epsilon = 8'hFF; greedy = 4'b1000;
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      wait_reqs(8);
      epsilon = 8'd0; greedy = 4'b0110;
      wait_reqs(4);
      epsilon = 8'h40; greedy = 4'b0100;
      wait_reqs(6);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
